// File: rtl/md_scheduler.sv
// md_scheduler: E-stage multiply/divide sequencer.
// Holds HI/LO, computes the mult/div result at start, models the fixed latency with a
// busy counter, and stalls MD-class instructions in D while an op is starting or in flight.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_uses_md,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] pend_hi_q;
  logic [31:0] pend_lo_q;
  logic        pend_wr_q;

  // Combinational result of the op being started, and its latency/commit flag
  logic [63:0] res_d;
  logic        res_wr_d;
  logic [3:0]  cnt_d;
  logic [31:0] divisor_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;

  assign start = op_valid & (md_op >= OP_MULT) & (md_op <= OP_DIVU) & (state_q == IDLE);
  assign busy  = busy_q;
  assign stall = d_uses_md & (busy_q | start);
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Result datapath: magnitudes divide unsigned, signs re-applied so quotient truncates
  // toward zero and remainder follows the dividend; a zero divisor is replaced by 1 so the
  // divider never sees it, and the result is flagged as not committed.
  always_comb begin
    res_d     = 64'd0;
    res_wr_d  = 1'b1;
    cnt_d     = MULT_CNT;
    divisor_s = (src_b == 32'd0) ? 32'd1 : src_b;
    abs_a_s   = src_a[31] ? (32'd0 - src_a) : src_a;
    abs_b_s   = divisor_s[31] ? (32'd0 - divisor_s) : divisor_s;
    q_mag_s   = abs_a_s / abs_b_s;
    r_mag_s   = abs_a_s % abs_b_s;
    case (md_op)
      OP_MULT: begin
        res_d = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
      end
      OP_MULTU: begin
        res_d = {32'd0, src_a} * {32'd0, src_b};
      end
      OP_DIV: begin
        cnt_d          = DIV_CNT;
        res_wr_d       = (src_b != 32'd0);
        res_d[31:0]    = (src_a[31] ^ src_b[31]) ? (32'd0 - q_mag_s) : q_mag_s;
        res_d[63:32]   = src_a[31] ? (32'd0 - r_mag_s) : r_mag_s;
      end
      OP_DIVU: begin
        cnt_d          = DIV_CNT;
        res_wr_d       = (src_b != 32'd0);
        res_d[31:0]    = src_a / divisor_s;
        res_d[63:32]   = src_a % divisor_s;
      end
      default: begin
        res_d    = 64'd0;
        res_wr_d = 1'b0;
        cnt_d    = MULT_CNT;
      end
    endcase
  end

  // Sequencer FSM: launches ops, counts latency, commits HI/LO, handles mthi/mtlo
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pend_hi_q <= res_d[63:32];
            pend_lo_q <= res_d[31:0];
            pend_wr_q <= res_wr_d;
            cnt_q     <= cnt_d;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end else if (op_valid && (md_op == OP_MTHI)) begin
            hi_q <= src_a;
          end else if (op_valid && (md_op == OP_MTLO)) begin
            lo_q <= src_a;
          end else begin
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_q == 4'd1) begin
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end else begin
              hi_q <= hi_q;
            end
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed testbench for md_scheduler: vector table plus hand-written corner sequences.
module tb_md_scheduler;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_uses_md;
  logic        start;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .d_uses_md(d_uses_md),
    .start    (start),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_start;
    int          exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one op for a single cycle, then count busy cycles (bounded).
  task automatic run_op(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic st, output int n);
    @(negedge clk);
    op_valid = v; md_op = op; src_a = a; src_b = b;
    #1 st = start;
    @(negedge clk);
    op_valid = 1'b0; md_op = 3'd0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  logic st;
  int   n;
  bit   stall_seen;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; op_valid = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    d_uses_md = 1'b0;

    vecs[0]  = '{1'b1, 3'd1, 32'hFFFFFFFD, 32'd5,        1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 32'd2,        1'b1, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{1'b1, 3'd3, 32'hFFFFFFF9, 32'd2,        1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{1'b1, 3'd4, 32'hFFFFFFF9, 32'd2,        1'b1, 10, 32'h00000001, 32'h7FFFFFFC};
    vecs[4]  = '{1'b1, 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 10, 32'h00000000, 32'h80000000};
    vecs[5]  = '{1'b1, 3'd5, 32'h12345678, 32'd0,        1'b0, 0,  32'h12345678, 32'h80000000};
    vecs[6]  = '{1'b1, 3'd4, 32'd5,        32'd0,        1'b1, 10, 32'h12345678, 32'h80000000};
    vecs[7]  = '{1'b1, 3'd6, 32'hCAFEF00D, 32'd0,        1'b0, 0,  32'h12345678, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 3'd0, 32'h11111111, 32'd3,        1'b0, 0,  32'h12345678, 32'hCAFEF00D};
    vecs[9]  = '{1'b1, 3'd7, 32'h22222222, 32'd3,        1'b0, 0,  32'h12345678, 32'hCAFEF00D};
    vecs[10] = '{1'b1, 3'd1, 32'd7,        32'hFFFFFFFD, 1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[11] = '{1'b1, 3'd3, 32'd7,        32'hFFFFFFFE, 1'b1, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[12] = '{1'b0, 3'd1, 32'd3,        32'd3,        1'b0, 0,  32'h00000001, 32'hFFFFFFFD};

    // Reset state
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_start", {31'd0, start}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].valid, vecs[i].op, vecs[i].a, vecs[i].b, st, n);
      check($sformatf("v%0d_start", i), {31'd0, st}, {31'd0, vecs[i].exp_start});
      check($sformatf("v%0d_busy_cycles", i), n, vecs[i].exp_busy);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // Stall with d_uses_md held: start cycle plus every busy cycle, low afterwards
    d_uses_md = 1'b1;
    @(negedge clk);
    op_valid = 1'b1; md_op = 3'd1; src_a = 32'd2; src_b = 32'd3;
    #1 check("stall_start_cycle", {31'd0, stall}, 32'd1);
    @(negedge clk);
    op_valid = 1'b0; md_op = 3'd0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      check($sformatf("stall_busy_cycle%0d", n), {31'd0, stall}, 32'd1);
      @(negedge clk);
    end
    check("stall_seq_busy_cycles", n, 5);
    check("stall_after_busy", {31'd0, stall}, 32'd0);
    check("stall_seq_lo", lo, 32'd6);
    d_uses_md = 1'b0;

    // d_uses_md low: stall never rises
    stall_seen = 1'b0;
    @(negedge clk);
    op_valid = 1'b1; md_op = 3'd1; src_a = 32'd4; src_b = 32'd4;
    #1 stall_seen = stall_seen | stall;
    @(negedge clk);
    op_valid = 1'b0; md_op = 3'd0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      stall_seen = stall_seen | stall;
      @(negedge clk);
    end
    check("nostall_seen", {31'd0, stall_seen}, 32'd0);
    check("nostall_lo", lo, 32'd16);

    // Ops injected mid-RUN are ignored
    run_op(1'b1, 3'd6, 32'h0BADF00D, 32'd0, st, n);
    @(negedge clk);
    op_valid = 1'b1; md_op = 3'd1; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    md_op = 3'd0; op_valid = 1'b0;
    @(negedge clk);
    op_valid = 1'b1; md_op = 3'd1; src_a = 32'd100; src_b = 32'd100;
    #1 check("inject_start", {31'd0, start}, 32'd0);
    @(negedge clk);
    md_op = 3'd5; src_a = 32'hDEADBEEF;
    @(negedge clk);
    md_op = 3'd6;
    @(negedge clk);
    op_valid = 1'b0; md_op = 3'd0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("inject_busy_tail", n, 1);
    check("inject_hi", hi, 32'd0);
    check("inject_lo", lo, 32'd12);

    // Asynchronous reset at busy cycle 3 of a div
    run_op(1'b1, 3'd5, 32'hDEAD0000, 32'd0, st, n);
    @(negedge clk);
    op_valid = 1'b1; md_op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    op_valid = 1'b0; md_op = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_hi", hi, 32'd0);
    check("mid_reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_hi", hi, 32'd0);
    run_op(1'b1, 3'd6, 32'hA5A5A5A5, 32'd0, st, n);
    check("post_reset_mtlo_lo", lo, 32'hA5A5A5A5);
    check("post_reset_mtlo_hi", hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
